// File: rtl/vga_layer_sequencer_pkg.sv
// Shared types, defaults and helpers for the VGA layer sequencer.
package vga_layer_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_ISSUE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [7:0] KEY_COLOUR_DEFAULT = 8'h09;

  // Layer index width; a single-layer build still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_layer_sequencer_if.sv
// Bundle between game FSM, sprite drawers and VGA adapter on one side and the sequencer on the other.
interface vga_layer_sequencer_if #(
  parameter int NUM_LAYERS   = 4,
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 7,
  parameter int COLOUR_WIDTH = 8
);

  logic                               start;
  logic [NUM_LAYERS-1:0]              layerEn;
  logic [NUM_LAYERS-1:0]              keyEn;
  logic [NUM_LAYERS-1:0]              layerStart;
  logic [NUM_LAYERS*X_WIDTH-1:0]      layerX;
  logic [NUM_LAYERS*Y_WIDTH-1:0]      layerY;
  logic [NUM_LAYERS*COLOUR_WIDTH-1:0] layerColour;
  logic [NUM_LAYERS-1:0]              layerWrite;
  logic [NUM_LAYERS-1:0]              layerDone;
  logic [X_WIDTH-1:0]                 x;
  logic [Y_WIDTH-1:0]                 y;
  logic [COLOUR_WIDTH-1:0]            colour;
  logic                               writeEn;
  logic                               done;
  logic                               busy;
  logic                               error;

  modport master (
    output start, layerEn, keyEn, layerX, layerY, layerColour, layerWrite, layerDone,
    input  layerStart, x, y, colour, writeEn, done, busy, error
  );

  modport slave (
    input  start, layerEn, keyEn, layerX, layerY, layerColour, layerWrite, layerDone,
    output layerStart, x, y, colour, writeEn, done, busy, error
  );

endinterface

// File: rtl/vga_layer_sequencer_mux.sv
// Combinational select of one drawer's x/y/colour/write/done slice by layer index.
module vga_layer_sequencer_mux #(
  parameter int NUM_LAYERS   = 4,
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 7,
  parameter int COLOUR_WIDTH = 8,
  parameter int IDX_W        = 2
) (
  input  logic [IDX_W-1:0]                   idx_i,
  input  logic [NUM_LAYERS*X_WIDTH-1:0]      layer_x_i,
  input  logic [NUM_LAYERS*Y_WIDTH-1:0]      layer_y_i,
  input  logic [NUM_LAYERS*COLOUR_WIDTH-1:0] layer_colour_i,
  input  logic [NUM_LAYERS-1:0]              layer_write_i,
  input  logic [NUM_LAYERS-1:0]              layer_done_i,
  output logic [X_WIDTH-1:0]                 x_o,
  output logic [Y_WIDTH-1:0]                 y_o,
  output logic [COLOUR_WIDTH-1:0]            colour_o,
  output logic                               write_o,
  output logic                               done_o
);

  always_comb begin
    // NOTE: every output is given a default before the loop so no path infers a latch.
    x_o      = '0;
    y_o      = '0;
    colour_o = '0;
    write_o  = 1'b0;
    done_o   = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (idx_i == IDX_W'(i)) begin
        x_o      = layer_x_i[i*X_WIDTH +: X_WIDTH];
        y_o      = layer_y_i[i*Y_WIDTH +: Y_WIDTH];
        colour_o = layer_colour_i[i*COLOUR_WIDTH +: COLOUR_WIDTH];
        write_o  = layer_write_i[i];
        done_o   = layer_done_i[i];
      end
    end
  end

endmodule

// File: rtl/vga_layer_sequencer.sv
// Frame compositor: walks enabled sprite drawers in index order, forwards their pixels with
// per-layer colour-key transparency and a per-layer stall timeout, then reports done.
module vga_layer_sequencer
  import vga_layer_sequencer_pkg::*;
#(
  parameter int                      NUM_LAYERS   = 4,
  parameter int                      X_WIDTH      = 8,
  parameter int                      Y_WIDTH      = 7,
  parameter int                      COLOUR_WIDTH = 8,
  parameter logic [COLOUR_WIDTH-1:0] KEY_COLOUR   = COLOUR_WIDTH'(KEY_COLOUR_DEFAULT),
  parameter int                      TIMEOUT      = 32768
) (
  input logic            clk,
  input logic            resetn,
  vga_layer_sequencer_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_LAYERS);
  localparam int CNT_W = $clog2(TIMEOUT);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_LAYERS-1:0]   pend_q, pend_d;
  logic [NUM_LAYERS-1:0]   key_q, key_d;
  logic                    err_q, err_d;
  logic [X_WIDTH-1:0]      x_q, x_d;
  logic [Y_WIDTH-1:0]      y_q, y_d;
  logic [COLOUR_WIDTH-1:0] colour_q, colour_d;
  logic                    we_q, we_d;

  logic [X_WIDTH-1:0]      sel_x;
  logic [Y_WIDTH-1:0]      sel_y;
  logic [COLOUR_WIDTH-1:0] sel_colour;
  logic                    sel_write;
  logic                    sel_done;

  vga_layer_sequencer_mux #(
    .NUM_LAYERS  (NUM_LAYERS),
    .X_WIDTH     (X_WIDTH),
    .Y_WIDTH     (Y_WIDTH),
    .COLOUR_WIDTH(COLOUR_WIDTH),
    .IDX_W       (IDX_W)
  ) u_mux (
    .idx_i         (idx_q),
    .layer_x_i     (bus.layerX),
    .layer_y_i     (bus.layerY),
    .layer_colour_i(bus.layerColour),
    .layer_write_i (bus.layerWrite),
    .layer_done_i  (bus.layerDone),
    .x_o           (sel_x),
    .y_o           (sel_y),
    .colour_o      (sel_colour),
    .write_o       (sel_write),
    .done_o        (sel_done)
  );

  // pend_q is the latched layer mask with already-served layers cleared, so "lowest set bit"
  // equals "lowest enabled layer at or above idx" and cannot wrap past the last layer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    key_d    = key_q;
    err_d    = err_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    we_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          pend_d  = bus.layerEn;
          key_d   = bus.keyEn;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_SEEK;
        end
      end

      ST_SEEK: begin
        state_d = ST_DONE;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
          if (pend_q[i]) begin
            idx_d   = IDX_W'(i);
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        x_d      = sel_x;
        y_d      = sel_y;
        colour_d = sel_colour;
        we_d     = sel_write & ~(key_q[idx_q] & (sel_colour == KEY_COLOUR));
        if (sel_done || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          if (!sel_done) err_d = 1'b1;
          pend_d[idx_q] = 1'b0;
          idx_d         = idx_q + IDX_W'(1);
          state_d       = ST_SEEK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (!bus.start) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
    if (!resetn) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      key_q    <= '0;
      err_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      key_q    <= key_d;
      err_q    <= err_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      we_q     <= we_d;
    end
  end

  assign bus.layerStart = (state_q == ST_ISSUE) ? (NUM_LAYERS'(1) << idx_q) : '0;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.colour     = colour_q;
  assign bus.writeEn    = we_q;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.busy       = (state_q == ST_SEEK) || (state_q == ST_ISSUE) || (state_q == ST_RUN);
  assign bus.error      = err_q;

endmodule

// File: tb/tb_vga_layer_sequencer.sv
// Self-checking bench: scripted drawers, frame-level reference model, table vectors and random frames.
module tb_vga_layer_sequencer;

  localparam int         NL   = 4;
  localparam int         TO   = 16;
  localparam logic [7:0] KEY  = 8'h09;
  localparam int         HANG = 99;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vga_layer_sequencer_if #(.NUM_LAYERS(NL), .X_WIDTH(8), .Y_WIDTH(7), .COLOUR_WIDTH(8)) bus ();

  vga_layer_sequencer #(
    .NUM_LAYERS  (NL),
    .X_WIDTH     (8),
    .Y_WIDTH     (7),
    .COLOUR_WIDTH(8),
    .KEY_COLOUR  (KEY),
    .TIMEOUT     (TO)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  // Drawer scripts: pixel k of layer i is presented on the k-th cycle after its start pulse;
  // done is raised with pixel sd[i] (HANG = never).
  logic [7:0] sx [NL][TO];
  logic [6:0] sy [NL][TO];
  logic [7:0] sc [NL][TO];
  logic       sw [NL][TO];
  int         sd [NL];
  bit         armed  [NL];
  bit         active [NL];
  int         kk     [NL];

  bit          rec = 1'b0;
  logic [63:0] act_p[$], act_w[$], exp_p[$], exp_w[$];
  int          exp_lat;
  logic        exp_err;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor and drawer models, both acting mid-cycle.
  always @(negedge clk) begin
    if (rec && resetn) begin
      if (bus.writeEn) act_w.push_back({9'd0, 32'(cyc), bus.x, bus.y, bus.colour});
      for (int i = 0; i < NL; i++)
        if (bus.layerStart[i]) act_p.push_back({32'(cyc), 32'(i)});
    end
    for (int i = 0; i < NL; i++) begin
      if (!resetn) begin
        armed[i]  = 1'b0;
        active[i] = 1'b0;
      end
      if (armed[i]) begin
        active[i] = 1'b1;
        kk[i]     = 0;
        armed[i]  = 1'b0;
      end
      if (active[i]) begin
        bus.layerX[i*8 +: 8]      = sx[i][kk[i]];
        bus.layerY[i*7 +: 7]      = sy[i][kk[i]];
        bus.layerColour[i*8 +: 8] = sc[i][kk[i]];
        bus.layerWrite[i]         = sw[i][kk[i]];
        bus.layerDone[i]          = (kk[i] == sd[i]);
        if (kk[i] == sd[i] || kk[i] == TO - 1) active[i] = 1'b0;
        else kk[i]++;
      end else begin
        bus.layerX[i*8 +: 8]      = 8'($urandom);
        bus.layerY[i*7 +: 7]      = 7'($urandom);
        bus.layerColour[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? KEY : 8'($urandom);
        bus.layerWrite[i]         = 1'($urandom);
        bus.layerDone[i]          = 1'($urandom);
      end
      if (resetn && bus.layerStart[i]) armed[i] = 1'b1;
    end
  end

  // Reference: each enabled layer costs one seek, one issue cycle and (last+1) run cycles;
  // run pixel k appears on the outputs one cycle after it is presented.
  task automatic model(input int c0, input logic [3:0] en, input logic [3:0] key);
    int t;
    int last;
    exp_p.delete();
    exp_w.delete();
    exp_err = 1'b0;
    t = c0 + 1;
    for (int i = 0; i < NL; i++) begin
      if (en[i]) begin
        exp_p.push_back({32'(t + 1), 32'(i)});
        last = (sd[i] < TO) ? sd[i] : TO - 1;
        if (sd[i] >= TO) exp_err = 1'b1;
        for (int k = 0; k <= last; k++)
          if (sw[i][k] && !(key[i] && sc[i][k] == KEY))
            exp_w.push_back({9'd0, 32'(t + 3 + k), sx[i][k], sy[i][k], sc[i][k]});
        t = t + 3 + last;
      end
    end
    exp_lat = t + 1 - c0;
  endtask

  task automatic load_fixed(input logic [3:0] hang);
    for (int i = 0; i < NL; i++) begin
      sd[i] = hang[i] ? HANG : 3;
      for (int k = 0; k < TO; k++) begin
        sx[i][k] = 8'(i * 16 + k);
        sy[i][k] = 7'(k);
        sc[i][k] = (i == 1 && k == 2) ? KEY : 8'(8'h40 + i * 8 + k);
        sw[i][k] = (k < 4);
      end
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < NL; i++) begin
      sd[i] = ($urandom_range(0, 5) == 0) ? HANG : int'($urandom_range(0, 6));
      for (int k = 0; k < TO; k++) begin
        sx[i][k] = 8'($urandom);
        sy[i][k] = 7'($urandom);
        sc[i][k] = ($urandom_range(0, 3) == 0) ? KEY : 8'($urandom);
        sw[i][k] = 1'($urandom);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_layerStart"}, 64'(bus.layerStart), 0);
    check({tag, "_x"},          64'(bus.x), 0);
    check({tag, "_y"},          64'(bus.y), 0);
    check({tag, "_colour"},     64'(bus.colour), 0);
    check({tag, "_writeEn"},    64'(bus.writeEn), 0);
    check({tag, "_done"},       64'(bus.done), 0);
    check({tag, "_busy"},       64'(bus.busy), 0);
    check({tag, "_error"},      64'(bus.error), 0);
  endtask

  task automatic run_frame(input logic [3:0] en, input logic [3:0] key,
                           output int np, output int nw, output int lat, output logic err);
    int c0;
    @(negedge clk);
    act_p.delete();
    act_w.delete();
    rec         = 1'b1;
    c0          = cyc;
    bus.layerEn = en;
    bus.keyEn   = key;
    bus.start   = 1'b1;
    model(c0, en, key);
    @(negedge clk);
    bus.layerEn = 4'($urandom);
    bus.keyEn   = 4'($urandom);
    while (!bus.done && (cyc - c0) < 400) @(negedge clk);
    lat = bus.done ? (cyc - c0) : -1;
    err = bus.error;
    check("done_latency", 64'(lat), 64'(exp_lat));
    check("error_flag", 64'(err), 64'(exp_err));
    repeat (3) @(negedge clk);
    check("done_held", 64'(bus.done), 1);
    check("busy_in_done", 64'(bus.busy), 0);
    rec = 1'b0;
    check("pulse_count", 64'(act_p.size()), 64'(exp_p.size()));
    for (int i = 0; i < act_p.size() && i < exp_p.size(); i++)
      check("pulse_cycle_layer", act_p[i], exp_p[i]);
    check("write_count", 64'(act_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < act_w.size() && i < exp_w.size(); i++)
      check("write_cycle_pixel", act_w[i], exp_w[i]);
    np = act_p.size();
    nw = act_w.size();
    bus.start = 1'b0;
    @(negedge clk);
    check("done_cleared", 64'(bus.done), 0);
    check("busy_idle", 64'(bus.busy), 0);
    check("write_idle", 64'(bus.writeEn), 0);
  endtask

  typedef struct {
    logic [3:0] en;
    logic [3:0] key;
    logic [3:0] hang;
    int         pulses;
    int         writes;
    logic       err;
    int         lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int   np, nw, lat, n;
    logic err;

    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   np, nw, lat, n;
    logic err;

    tbl[0] = '{4'hF, 4'h0, 4'h0, 4, 16, 1'b0, 26};
    tbl[1] = '{4'hA, 4'h0, 4'h0, 2,  8, 1'b0, 14};
    tbl[2] = '{4'h2, 4'h2, 4'h0, 1,  3, 1'b0,  8};
    tbl[3] = '{4'h2, 4'h0, 4'h0, 1,  4, 1'b0,  8};
    tbl[4] = '{4'h0, 4'h0, 4'h0, 0,  0, 1'b0,  2};
    tbl[5] = '{4'hF, 4'h0, 4'h4, 4, 16, 1'b1, 38};
    tbl[6] = '{4'hF, 4'hF, 4'h0, 4, 15, 1'b0, 26};
    tbl[7] = '{4'h8, 4'h0, 4'h8, 1,  4, 1'b1, 20};

    bus.start   = 1'b0;
    bus.layerEn = '0;
    bus.keyEn   = '0;
    load_fixed(4'h0);

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    #1 resetn = 1'b1;

    for (int v = 0; v < 8; v++) begin
      load_fixed(tbl[v].hang);
      run_frame(tbl[v].en, tbl[v].key, np, nw, lat, err);
      check("tbl_pulses", 64'(np), 64'(tbl[v].pulses));
      check("tbl_writes", 64'(nw), 64'(tbl[v].writes));
      check("tbl_error", 64'(err), 64'(tbl[v].err));
      check("tbl_latency", 64'(lat), 64'(tbl[v].lat));
      check("tbl_error_sticky_idle", 64'(bus.error), 64'(tbl[v].err));
    end

    // Reset asserted while layer 1 is running, then a fresh frame from layer 0.
    load_fixed(4'h0);
    @(negedge clk);
    act_p.delete();
    act_w.delete();
    rec         = 1'b1;
    bus.layerEn = 4'hF;
    bus.keyEn   = 4'h0;
    bus.start   = 1'b1;
    n = 0;
    while (act_p.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_layer1", 64'(act_p.size() >= 2), 1);
    repeat (2) @(negedge clk);
    check("busy_before_reset", 64'(bus.busy), 1);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("midreset");
    rec       = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
    run_frame(4'hF, 4'h0, np, nw, lat, err);
    check("restart_pulses", 64'(np), 4);
    check("restart_writes", 64'(nw), 16);

    for (int f = 0; f < 24; f++) begin
      load_random();
      run_frame(4'($urandom), 4'($urandom), np, nw, lat, err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
